// File: rtl/flute_tone_gen_if.sv
// Note-select / audio-output bundle between the note counter and flute_tone_gen.
// Optional macro FLUTE_OCTAVE_EN adds the oct_up signal.
interface flute_tone_gen_if;
    logic       en;
    logic [3:0] num;
`ifdef FLUTE_OCTAVE_EN
    logic       oct_up;
`endif
    logic       tone;
    logic       playing;
    logic [3:0] note_out;
    logic       period_tick;

`ifdef FLUTE_OCTAVE_EN
    modport master (
        output en, num, oct_up,
        input  tone, playing, note_out, period_tick
    );
    modport slave (
        input  en, num, oct_up,
        output tone, playing, note_out, period_tick
    );
`else
    modport master (
        output en, num,
        input  tone, playing, note_out, period_tick
    );
    modport slave (
        input  en, num,
        output tone, playing, note_out, period_tick
    );
`endif
endinterface

// File: rtl/flute_tone_gen.sv
// 50%-duty square-wave note generator; note changes take effect only at full-period boundaries.
// Optional macro FLUTE_OCTAVE_EN: oct_up halves the half-period when num is sampled.
module flute_tone_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    flute_tone_gen_if.slave   bus
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    function automatic int unsigned note_hz(input int unsigned idx);
        case (idx)
            1:       return 262;
            2:       return 294;
            3:       return 330;
            4:       return 349;
            5:       return 392;
            6:       return 440;
            7:       return 494;
            8:       return 523;
            9:       return 587;
            10:      return 659;
            11:      return 698;
            12:      return 784;
            13:      return 880;
            14:      return 988;
            15:      return 1047;
            default: return 0;
        endcase
    endfunction

    function automatic logic [16*CNT_W-1:0] build_half_tbl();
        logic [16*CNT_W-1:0] tbl;
        tbl = '0;
        for (int unsigned i = 1; i < 16; i++) begin
            tbl[i*CNT_W +: CNT_W] = CNT_W'(CLK_HZ / (2 * note_hz(i)));
        end
        return tbl;
    endfunction

    localparam logic [16*CNT_W-1:0] HALF_TBL = build_half_tbl();

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             tone_q, tone_d;
    logic             playing_q, playing_d;
    logic [3:0]       note_q, note_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half_sel;

    // Half-period for the note being sampled right now (only meaningful when num != 0)
    always_comb begin
        half_sel = HALF_TBL[int'(bus.num)*CNT_W +: CNT_W];
`ifdef FLUTE_OCTAVE_EN
        if (bus.oct_up) begin
            half_sel = half_sel >> 1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            note_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            tone_q    <= tone_d;
            playing_q <= playing_d;
            note_q    <= note_d;
            tick_q    <= tick_d;
        end
    end

    // half_q keeps the half-period latched at the last boundary so the
    // high->low reload ignores any num/oct_up change inside the period.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        tone_d    = tone_q;
        playing_d = playing_q;
        note_d    = note_q;
        tick_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                note_d    = '0;
                cnt_d     = '0;
                if (bus.en && (bus.num != 4'd0)) begin
                    state_d   = PLAY;
                    tone_d    = 1'b1;
                    tick_d    = 1'b1;
                    playing_d = 1'b1;
                    note_d    = bus.num;
                    half_d    = half_sel;
                    cnt_d     = half_sel - CNT_W'(1);
                end
            end

            PLAY: begin
                if (!bus.en) begin
                    state_d   = IDLE;
                    tone_d    = 1'b0;
                    playing_d = 1'b0;
                    note_d    = '0;
                    cnt_d     = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (tone_q) begin
                    tone_d = 1'b0;
                    cnt_d  = half_q - CNT_W'(1);
                end else if (bus.num == 4'd0) begin
                    state_d   = IDLE;
                    tone_d    = 1'b0;
                    playing_d = 1'b0;
                    note_d    = '0;
                    cnt_d     = '0;
                end else begin
                    tone_d = 1'b1;
                    tick_d = 1'b1;
                    note_d = bus.num;
                    half_d = half_sel;
                    cnt_d  = half_sel - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tone        = tone_q;
    assign bus.playing     = playing_q;
    assign bus.note_out    = note_q;
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_flute_tone_gen.sv
// Directed bench for flute_tone_gen with a position-based reference model and scoreboard queue.
// Build with FLUTE_OCTAVE_EN defined to also exercise the octave feature.
module tb_flute_tone_gen;

    localparam int unsigned CLK_HZ = 52_800;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flute_tone_gen_if bus ();

    flute_tone_gen #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (18)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] exp_q [$];

    // reference model: position within current period, counting up from 0
    bit         m_play = 1'b0;
    int         m_pos  = 0;
    int         m_half = 0;
    logic [3:0] m_note = '0;

    int cyc           = 0;
    int last_tick_cyc = 0;
    int tick_gap      = 0;
    int high_run      = 0;
    int last_high     = 0;

    function automatic int half_of(input logic [3:0] n, input logic oct);
        int unsigned freq [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                   523, 587, 659, 698, 784, 880, 988, 1047};
        int h;
        h = int'(CLK_HZ / (2 * freq[n]));
        if (oct) h = h / 2;
        return h;
    endfunction

    function automatic logic oct_in();
`ifdef FLUTE_OCTAVE_EN
        return bus.oct_up;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push();
        logic e_tick;
        logic [3:0] e_note;
        e_tick = 1'b0;
        if (rst) begin
            m_play = 1'b0;
            m_pos  = 0;
            m_note = '0;
        end else if (!m_play) begin
            if (bus.en && bus.num != 4'd0) begin
                m_play = 1'b1;
                m_pos  = 0;
                m_half = half_of(bus.num, oct_in());
                m_note = bus.num;
                e_tick = 1'b1;
            end
        end else if (!bus.en) begin
            m_play = 1'b0;
            m_note = '0;
        end else begin
            m_pos++;
            if (m_pos == 2 * m_half) begin
                if (bus.num == 4'd0) begin
                    m_play = 1'b0;
                    m_note = '0;
                end else begin
                    m_pos  = 0;
                    m_half = half_of(bus.num, oct_in());
                    m_note = bus.num;
                    e_tick = 1'b1;
                end
            end
        end
        e_note = m_play ? m_note : 4'd0;
        exp_q.push_back({(m_play && m_pos < m_half), m_play, e_note, e_tick});
    endtask

    task automatic step(input string tag);
        logic [6:0] obs;
        model_push();
        @(posedge clk);
        #1;
        cyc++;
        obs = {bus.tone, bus.playing, bus.note_out, bus.period_tick};
        check(tag, 32'(obs), 32'(exp_q.pop_front()));
        if (bus.period_tick === 1'b1) begin
            tick_gap      = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
        end
        if (bus.tone === 1'b1) begin
            high_run++;
        end else begin
            if (high_run != 0) last_high = high_run;
            high_run = 0;
        end
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 400; i++) begin
            step(tag);
            if (bus.period_tick === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL %s_timeout observed=no_tick expected=tick", tag);
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.num = 4'd0;
`ifdef FLUTE_OCTAVE_EN
        bus.oct_up = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) step("rst_init");
        check("rst_init_outs", 32'({bus.tone, bus.playing, bus.note_out, bus.period_tick}), 32'd0);
        rst = 1'b0;
        repeat (2) step("idle");

        // steady note 6: 60/60 phases
        bus.en  = 1'b1;
        bus.num = 4'd6;
        step("start6");
        check("start6_tick", 32'(bus.period_tick), 32'd1);
        check("start6_note", 32'(bus.note_out), 32'd6);
        repeat (249) step("play6");
        check("play6_gap", 32'(tick_gap), 32'd120);
        check("play6_high", 32'(last_high), 32'd60);

        // change to note 8 at cycle 20 of a high phase
        wait_tick("sync3");
        repeat (19) step("hold6");
        bus.num = 4'd8;
        repeat (300) step("play8");
        check("play8_gap", 32'(tick_gap), 32'd100);
        check("play8_high", 32'(last_high), 32'd50);
        check("play8_note", 32'(bus.note_out), 32'd8);

        // num -> 0 mid-period: period completes then idle
        wait_tick("sync4");
        repeat (40) step("pre_stop");
        bus.num = 4'd0;
        repeat (150) step("stop");
        check("stop_playing", 32'(bus.playing), 32'd0);
        check("stop_note", 32'(bus.note_out), 32'd0);
        check("stop_no_tick", 32'(cyc - last_tick_cyc > 150), 32'd1);

        // en abort at cycle 30 of a high phase, then restart
        bus.num = 4'd6;
        wait_tick("sync5");
        repeat (29) step("pre_abort");
        bus.en = 1'b0;
        step("abort");
        check("abort_tone", 32'(bus.tone), 32'd0);
        check("abort_playing", 32'(bus.playing), 32'd0);
        step("muted");
        bus.en = 1'b1;
        step("restart");
        check("restart_tick", 32'(bus.period_tick), 32'd1);
        repeat (130) step("replay");
        check("replay_high", 32'(last_high), 32'd60);

        // synchronous reset during play
        repeat (20) step("pre_rst");
        rst = 1'b1;
        step("rst_play");
        check("rst_play_outs", 32'({bus.tone, bus.playing, bus.note_out, bus.period_tick}), 32'd0);
        repeat (2) step("rst_hold");
        rst    = 1'b0;
        bus.en = 1'b0;
        repeat (3) step("post_rst");

`ifdef FLUTE_OCTAVE_EN
        bus.en     = 1'b1;
        bus.num    = 4'd6;
        bus.oct_up = 1'b1;
        repeat (130) step("oct_play");
        check("oct_gap", 32'(tick_gap), 32'd60);
        check("oct_high", 32'(last_high), 32'd30);
        wait_tick("oct_sync");
        repeat (10) step("oct_pre");
        bus.oct_up = 1'b0;
        repeat (30) step("oct_hold");
        check("oct_hold_gap", 32'(tick_gap), 32'd60);
        repeat (250) step("oct_off");
        check("oct_off_gap", 32'(tick_gap), 32'd120);
        check("oct_off_high", 32'(last_high), 32'd60);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
